// File: rtl/gate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_pkg
// Brief    : Shared LSTM gate definitions: data defaults and sequencer states.
// Revision : 1.0
// ============================================================================
package gate_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Address width for a memory of 'depth' words, never narrower than 1 bit.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_if
// Brief    : Control/address/result bundle between a gate sequencer and its
//            datapath + memories.
// Revision : 1.0
// ============================================================================
interface gate_seq_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 12
);
    logic             start;
    logic             busy;
    logic [AW-1:0]    addr_x;
    logic [AW-1:0]    addr_w;
    logic [AW-1:0]    addr_h;
    logic [AW-1:0]    addr_u;
    logic [AW-1:0]    addr_b;
    logic             acc_x;
    logic             acc_h;
    logic             mask_x;
    logic             mask_h;
    logic [WIDTH-1:0] i_act;
    logic [WIDTH-1:0] o_act;
    logic             o_valid;
    logic [AW-1:0]    o_idx;
    logic             done;

    modport master (
        input  start, i_act,
        output busy, addr_x, addr_w, addr_h, addr_u, addr_b,
               acc_x, acc_h, mask_x, mask_h, o_act, o_valid, o_idx, done
    );

    modport slave (
        output start, i_act,
        input  busy, addr_x, addr_w, addr_h, addr_u, addr_b,
               acc_x, acc_h, mask_x, mask_h, o_act, o_valid, o_idx, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_idx_cnt
// Brief    : Nested element/neuron counter (k wraps at K_MAX, n advances on
//            wrap) exposing both current and next values plus last flags.
// Revision : 1.0
// ============================================================================
module seq_idx_cnt #(
    parameter int            AW    = 1,
    parameter logic [AW-1:0] K_MAX = '0,
    parameter logic [AW-1:0] N_MAX = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] k,
    output logic [AW-1:0] n,
    output logic [AW-1:0] k_nxt,
    output logic [AW-1:0] n_nxt,
    output logic          k_last,
    output logic          step_last
);
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] n_q, n_d;

    always_comb begin
        k_d = k_q;
        n_d = n_q;
        if (clr) begin
            k_d = '0;
            n_d = '0;
        end else if (en) begin
            if (k_q == K_MAX) begin
                k_d = '0;
                n_d = n_q + AW'(1);
            end else begin
                k_d = k_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q <= '0;
            n_q <= '0;
        end else begin
            k_q <= k_d;
            n_q <= n_d;
        end
    end

    assign k         = k_q;
    assign n         = n_q;
    assign k_nxt     = k_d;
    assign n_nxt     = n_d;
    assign k_last    = (k_q == K_MAX);
    assign step_last = (k_q == K_MAX) && (n_q == N_MAX);

endmodule
`default_nettype wire

// File: rtl/gate_seq.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq
// Brief    : Sequencer for one LSTM gate: issues x/w/h/u/b addresses, drives
//            MAC accumulate/mask controls and captures one activation per
//            neuron with valid/done strobes.
// Revision : 1.0
// ============================================================================
module gate_seq
    import gate_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int X_LEN   = 53,
    parameter int H_LEN   = 53,
    parameter int NEURONS = 53
) (
    input  logic       clk,
    input  logic       rst,
    gate_seq_if.master bus
);
    localparam int N  = (X_LEN > H_LEN) ? X_LEN : H_LEN;
    localparam int AW = calc_aw(NEURONS * N);

    // Limits are held as "max index" values so they always fit in AW bits.
    localparam logic [AW-1:0] X_MAX  = AW'(X_LEN - 1);
    localparam logic [AW-1:0] H_MAX  = AW'(H_LEN - 1);
    localparam logic [AW-1:0] K_MAX  = AW'(N - 1);
    localparam logic [AW-1:0] N_MAX  = AW'(NEURONS - 1);
    localparam logic [AW-1:0] X_STEP = AW'(X_LEN);
    localparam logic [AW-1:0] H_STEP = AW'(H_LEN);

    state_t state_q;
    logic   busy_q;

    logic          start_ok, run, step_adv;
    logic [AW-1:0] k, n, k_nxt, n_nxt;
    logic          k_last, step_last;
    logic [AW-1:0] kx, kh;

    logic [AW-1:0] base_w_q, base_w_d, base_u_q, base_u_d;
    logic [AW-1:0] addr_x_q, addr_x_d, addr_w_q, addr_w_d;
    logic [AW-1:0] addr_h_q, addr_h_d, addr_u_q, addr_u_d;
    logic [AW-1:0] addr_b_q, addr_b_d;

    logic             acc_q, acc_d, mask_x_q, mask_x_d, mask_h_q, mask_h_d;
    logic             cap1_q, cap1_d, cap2_q, cap2_d;
    logic [AW-1:0]    n1_q, n1_d, n2_q, n2_d;
    logic [WIDTH-1:0] o_act_q, o_act_d;
    logic [AW-1:0]    o_idx_q, o_idx_d;
    logic             o_valid_q, o_valid_d, done_q, done_d;

    assign start_ok = (state_q == ST_IDLE) && bus.start;
    assign run      = (state_q == ST_RUN);
    assign step_adv = run && !step_last;

    seq_idx_cnt #(
        .AW    (AW),
        .K_MAX (K_MAX),
        .N_MAX (N_MAX)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .en        (step_adv),
        .k         (k),
        .n         (n),
        .k_nxt     (k_nxt),
        .n_nxt     (n_nxt),
        .k_last    (k_last),
        .step_last (step_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step_last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (done_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Addresses are computed from the counter's next value so they land in
    // the same cycle as the issue step; beyond the vector length they clamp.
    always_comb begin
        kx = (k_nxt > X_MAX) ? X_MAX : k_nxt;
        kh = (k_nxt > H_MAX) ? H_MAX : k_nxt;

        base_w_d = base_w_q;
        base_u_d = base_u_q;
        if (start_ok) begin
            base_w_d = '0;
            base_u_d = '0;
        end else if (step_adv && k_last) begin
            base_w_d = base_w_q + X_STEP;
            base_u_d = base_u_q + H_STEP;
        end

        addr_x_d = addr_x_q;
        addr_w_d = addr_w_q;
        addr_h_d = addr_h_q;
        addr_u_d = addr_u_q;
        addr_b_d = addr_b_q;
        if (start_ok || step_adv) begin
            addr_x_d = kx;
            addr_w_d = base_w_d + kx;
            addr_h_d = kh;
            addr_u_d = base_u_d + kh;
            addr_b_d = n_nxt;
        end
    end

    // Controls trail the issue step by the one-cycle memory latency; the
    // capture strobe trails the last element by one more for the MAC output.
    always_comb begin
        acc_d     = run && (k != '0);
        mask_x_d  = run && (k > X_MAX);
        mask_h_d  = run && (k > H_MAX);
        cap1_d    = run && k_last;
        n1_d      = n;
        cap2_d    = cap1_q;
        n2_d      = n1_q;
        o_valid_d = cap2_q;
        done_d    = cap2_q && (n2_q == N_MAX);
        o_act_d   = cap2_q ? bus.i_act : o_act_q;
        o_idx_d   = cap2_q ? n2_q : o_idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_w_q  <= '0;
            base_u_q  <= '0;
            addr_x_q  <= '0;
            addr_w_q  <= '0;
            addr_h_q  <= '0;
            addr_u_q  <= '0;
            addr_b_q  <= '0;
            acc_q     <= 1'b0;
            mask_x_q  <= 1'b0;
            mask_h_q  <= 1'b0;
            cap1_q    <= 1'b0;
            cap2_q    <= 1'b0;
            n1_q      <= '0;
            n2_q      <= '0;
            o_act_q   <= '0;
            o_idx_q   <= '0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            base_w_q  <= base_w_d;
            base_u_q  <= base_u_d;
            addr_x_q  <= addr_x_d;
            addr_w_q  <= addr_w_d;
            addr_h_q  <= addr_h_d;
            addr_u_q  <= addr_u_d;
            addr_b_q  <= addr_b_d;
            acc_q     <= acc_d;
            mask_x_q  <= mask_x_d;
            mask_h_q  <= mask_h_d;
            cap1_q    <= cap1_d;
            cap2_q    <= cap2_d;
            n1_q      <= n1_d;
            n2_q      <= n2_d;
            o_act_q   <= o_act_d;
            o_idx_q   <= o_idx_d;
            o_valid_q <= o_valid_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.addr_x  = addr_x_q;
    assign bus.addr_w  = addr_w_q;
    assign bus.addr_h  = addr_h_q;
    assign bus.addr_u  = addr_u_q;
    assign bus.addr_b  = addr_b_q;
    assign bus.acc_x   = acc_q;
    assign bus.acc_h   = acc_q;
    assign bus.mask_x  = mask_x_q;
    assign bus.mask_h  = mask_h_q;
    assign bus.o_act   = o_act_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_idx   = o_idx_q;
    assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: doc/gate_seq.md
Name: gate_seq

Overview:
- Sequencer for one LSTM gate unit: the two-MAC datapath (x·w and h·u) plus bias, adder and sigmoid.
- Steps through NEURONS neurons back-to-back.
- For each neuron it issues memory addresses for x, w, h, u and b, and drives the MAC accumulate controls and operand masks.
- Captures each activation result and raises a valid strobe per neuron, then a done pulse after the last neuron.

Parameters:
- WIDTH, 32, data word width of the captured activation
- X_LEN, 53, number of input elements per neuron
- H_LEN, 53, number of hidden elements per neuron
- NEURONS, 53, neurons per gate pass
- N = max(X_LEN, H_LEN), localparam, steps per neuron
- AW, clog2(NEURONS*N), address width for all address outputs

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a gate pass
- busy  out  1  pass in progress
- addr_x  out  AW  x memory address (k)
- addr_w  out  AW  w memory address (n*X_LEN + k)
- addr_h  out  AW  h memory address (k)
- addr_u  out  AW  u memory address (n*H_LEN + k)
- addr_b  out  AW  bias address (n)
- acc_x  out  1  mac_x accumulate: 0 = load product, 1 = add to sum
- acc_h  out  1  mac_h accumulate, same encoding
- mask_x  out  1  force mac_x operand to zero (k ≥ X_LEN)
- mask_h  out  1  force mac_h operand to zero (k ≥ H_LEN)
- i_act  in  WIDTH  sigmoid output of the datapath
- o_act  out  WIDTH  registered activation for neuron o_idx
- o_valid  out  1  one-cycle strobe; o_act/o_idx valid
- o_idx  out  AW  neuron index of o_act
- done  out  1  one-cycle pulse with the final o_valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs and counters 0. Takes effect mid-pass: the pass is abandoned, no o_valid or done. After reset releases, a new start is required.
- States: IDLE → RUN on start; RUN → DRAIN after the issue step n=NEURONS-1, k=N-1; DRAIN → IDLE when done is asserted.
- start is honoured only in IDLE; it is ignored while busy.
- busy is high from the cycle after start is sampled through the done cycle inclusive.
- Issue step t = n*N + k runs in cycle S+1+t, where S is the edge that sampled start. Counters: k counts 0..N-1 and wraps, n increments on wrap. Neurons run back-to-back with no idle cycle.
- Address outputs are registered and change only at issue steps.
  - addr_x and addr_w clamp to their k = X_LEN-1 values when k ≥ X_LEN.
  - addr_h and addr_u clamp likewise for H_LEN.
  - During DRAIN, addresses hold their last values.
- Memory read latency is 1 cycle, so acc_x, acc_h, mask_x and mask_h are delayed one cycle to align with the data.
  - In data cycle S+2+t: acc = 0 if k = 0, else 1.
  - mask_x = (k ≥ X_LEN); mask_h = (k ≥ H_LEN).
  - Outside data cycles: acc = 0, masks = 0.
- MAC output updates at the end of each data cycle, so i_act for neuron n is valid in cycle S+3+n*N+N-1.
- That cycle, gate_seq registers i_act into o_act and sets o_idx = n. o_valid is high the following cycle, S+4+n*N+N-1, for one cycle.
- done coincides with o_valid for n = NEURONS-1. busy drops the cycle after done.
- Total pass length: start sample to done = NEURONS*N + 3 cycles.
- o_act and o_idx hold their value until the next capture.
- Arithmetic: unsigned counters. addr_w and addr_u are computed incrementally (running base += X_LEN or H_LEN per neuron); no multiplier.

Decomposition:
- Shared lstm package: WIDTH/FRAC defaults and the state encoding (IDLE, RUN, DRAIN).
- One natural sub-module, seq_idx_cnt: the nested k/n counter with wrap and last-step flags.
- The output capture/strobe pipeline stays inline.

Test Plan:
- Basic pass, X_LEN=3, H_LEN=2, NEURONS=2, start sampled at edge 0:
  - addr_x 0,1,2,0,1,2 in cycles 1–6; addr_w 0,1,2,3,4,5; addr_u 0,1,1,2,3,3.
  - acc_x/acc_h 0,1,1,0,1,1 in cycles 2–7; mask_h high in cycles 4 and 7; mask_x never high.
  - o_valid at cycle 6 (o_idx 0) and cycle 9 (o_idx 1); done at cycle 9; busy high cycles 1–9.
- Capture check: drive i_act = 0x00800000 in cycle 5 and 0x00C00000 in cycle 8 → o_act equals those values at cycles 6 and 9.
- start pulses at cycles 3 and 9 during a pass → ignored; exactly one done, timing unchanged. A start at cycle 10 begins a new pass.
- rst low at cycle 5 → all outputs 0 asynchronously, no o_valid or done follows. Re-run after release → full correct pass.
- X_LEN = H_LEN = 1, NEURONS = 1 → acc_x = 0 in cycle 2, o_valid and done both in cycle 4.
- Asymmetric X_LEN=2, H_LEN=4, NEURONS=1 → mask_x high in data cycles for k = 2, 3; addr_x holds at 1 during those steps.
